// File: rtl/fpadd_operand_loader.sv
// -----------------------------------------------------------------------------
// fpadd_operand_loader
//
// User-input front end for the FP adder board. A bouncy push button and an
// 8-bit switch bank are turned into the two single-precision operands that
// feed the adder. Every debounced press latches the switch byte into the next
// operand byte, most significant byte of A first, then B. After the eighth
// byte the operands are flagged valid; the next press starts a new entry.
//
// Ports
//   clk             system clock, rising edge
//   rst             synchronous active-high reset
//   noisy_level     raw push-button level (asynchronous, bouncy)
//   sw[7:0]         byte value, sampled in the load cycle
//   inp_a[31:0]     operand A
//   inp_b[31:0]     operand B
//   operands_valid  high while both operands are complete
//   byte_idx[2:0]   next byte to load: 0..3 -> A[31:24]..A[7:0],
//                   4..7 -> B[31:24]..B[7:0]
//   load_ack        one-cycle pulse in the cycle after each byte write
//
// FSM states
//   state      | meaning
//   ST_LOAD_A  | collecting bytes 0..3 into operand A
//   ST_LOAD_B  | collecting bytes 4..7 into operand B
//   ST_DONE    | both operands complete; next press restarts entry
// -----------------------------------------------------------------------------
module fpadd_operand_loader #(
  parameter int unsigned DEBOUNCE_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        noisy_level,
  input  logic [7:0]  sw,
  output logic [31:0] inp_a,
  output logic [31:0] inp_b,
  output logic        operands_valid,
  output logic [2:0]  byte_idx,
  output logic        load_ack
);

  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  // The counter value on the edge whose increment would reach DEBOUNCE_CYCLES.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_LOAD_A = 2'd0,
    ST_LOAD_B = 2'd1,
    ST_DONE   = 2'd2
  } state_e;

  // ---------------------------------------------------------------------------
  // Two-flop synchronizer
  // ---------------------------------------------------------------------------
  logic sync1_q;
  logic sync2_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= noisy_level;
      sync2_q <= sync1_q;
    end
  end

  // ---------------------------------------------------------------------------
  // Debouncer: a level change is accepted only after DEBOUNCE_CYCLES
  // consecutive synchronized cycles that disagree with the accepted level.
  // Any agreeing cycle restarts the count, which is what rejects chatter.
  // ---------------------------------------------------------------------------
  logic             stable_q;
  logic             stable_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    stable_d = stable_q;
    cnt_d    = '0;
    if (sync2_q != stable_q) begin
      if (cnt_q == CNT_LAST) begin
        stable_d = sync2_q;
        cnt_d    = '0;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stable_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Press detect: one strobe per accepted rising level, none on release.
  // ---------------------------------------------------------------------------
  logic stable_dly_q;
  logic press;

  always_ff @(posedge clk) begin
    if (rst) begin
      stable_dly_q <= 1'b0;
    end else begin
      stable_dly_q <= stable_q;
    end
  end

  assign press = stable_q & ~stable_dly_q;

  // ---------------------------------------------------------------------------
  // Byte-lane insert: lane 0 is the most significant byte.
  // ---------------------------------------------------------------------------
  function automatic logic [31:0] put_byte(input logic [31:0] word,
                                           input logic [1:0]  lane,
                                           input logic [7:0]  val);
    logic [31:0] res;
    res = word;
    case (lane)
      2'd0:    res[31:24] = val;
      2'd1:    res[23:16] = val;
      2'd2:    res[15:8]  = val;
      default: res[7:0]   = val;
    endcase
    return res;
  endfunction

  // ---------------------------------------------------------------------------
  // Entry FSM with registered outputs
  // ---------------------------------------------------------------------------
  state_e      state_q;
  logic [31:0] inp_a_q;
  logic [31:0] inp_b_q;
  logic        valid_q;
  logic [2:0]  byte_idx_q;
  logic        load_ack_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_LOAD_A;
      inp_a_q    <= '0;
      inp_b_q    <= '0;
      valid_q    <= 1'b0;
      byte_idx_q <= 3'd0;
      load_ack_q <= 1'b0;
    end else begin
      load_ack_q <= press;
      if (press) begin
        case (state_q)
          ST_LOAD_A: begin
            inp_a_q    <= put_byte(inp_a_q, byte_idx_q[1:0], sw);
            byte_idx_q <= byte_idx_q + 3'd1;
            if (byte_idx_q == 3'd3) begin
              state_q <= ST_LOAD_B;
            end
          end
          ST_LOAD_B: begin
            inp_b_q <= put_byte(inp_b_q, byte_idx_q[1:0], sw);
            if (byte_idx_q == 3'd7) begin
              byte_idx_q <= 3'd0;
              valid_q    <= 1'b1;
              state_q    <= ST_DONE;
            end else begin
              byte_idx_q <= byte_idx_q + 3'd1;
            end
          end
          ST_DONE: begin
            // The restart press already carries the first byte of a new A;
            // the other bytes keep their old values until overwritten.
            valid_q          <= 1'b0;
            inp_a_q[31:24]   <= sw;
            byte_idx_q       <= 3'd1;
            state_q          <= ST_LOAD_A;
          end
          default: begin
            state_q    <= ST_LOAD_A;
            byte_idx_q <= 3'd0;
          end
        endcase
      end
    end
  end

  assign inp_a          = inp_a_q;
  assign inp_b          = inp_b_q;
  assign operands_valid = valid_q;
  assign byte_idx       = byte_idx_q;
  assign load_ack       = load_ack_q;

endmodule

// File: tb/tb_fpadd_operand_loader.sv
module tb_fpadd_operand_loader;

  logic        clk;
  logic        rst;
  logic        noisy_level;
  logic [7:0]  sw;
  logic [31:0] inp_a;
  logic [31:0] inp_b;
  logic        operands_valid;
  logic [2:0]  byte_idx;
  logic        load_ack;

  int n_checks;
  int n_fail;
  int ack_cnt;
  int ack_base;

  fpadd_operand_loader #(.DEBOUNCE_CYCLES(4)) dut (
    .clk            (clk),
    .rst            (rst),
    .noisy_level    (noisy_level),
    .sw             (sw),
    .inp_a          (inp_a),
    .inp_b          (inp_b),
    .operands_valid (operands_valid),
    .byte_idx       (byte_idx),
    .load_ack       (load_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial ack_cnt = 0;
  always @(negedge clk) begin
    if (load_ack === 1'b1) ack_cnt = ack_cnt + 1;
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks = n_checks + 1;
    assert (obs === exp) else begin
      n_fail = n_fail + 1;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic clean_press(input logic [7:0] val);
    sw = val;
    noisy_level = 1'b1;
    tick(20);
    noisy_level = 1'b0;
    tick(20);
  endtask

  initial begin
    n_checks = 0;
    n_fail = 0;
    rst = 1'b1;
    noisy_level = 1'b0;
    sw = 8'h00;
    tick(3);
    rst = 1'b0;
    tick(2);
    check("reset_inp_a", inp_a, 32'h0);
    check("reset_inp_b", inp_b, 32'h0);
    check("reset_valid", {31'd0, operands_valid}, 32'd0);
    check("reset_byte_idx", {29'd0, byte_idx}, 32'd0);
    check("reset_load_ack", {31'd0, load_ack}, 32'd0);

    // Latency: the first press of the full entry; edge t is the next posedge.
    ack_base = ack_cnt;
    sw = 8'h6b;
    noisy_level = 1'b1;
    tick(6);   // just after edge t+5
    check("lat_t5_byte_idx", {29'd0, byte_idx}, 32'd0);
    check("lat_t5_inp_a", inp_a, 32'h0);
    check("lat_t5_load_ack", {31'd0, load_ack}, 32'd0);
    tick(1);   // just after edge t+6
    check("lat_t6_inp_a", inp_a, 32'h6b000000);
    check("lat_t6_byte_idx", {29'd0, byte_idx}, 32'd1);
    check("lat_t6_load_ack", {31'd0, load_ack}, 32'd1);
    tick(1);
    check("lat_t7_load_ack", {31'd0, load_ack}, 32'd0);
    tick(12);
    noisy_level = 1'b0;
    tick(20);

    // Remaining seven bytes of the full entry.
    clean_press(8'h64);
    clean_press(8'hb2);
    clean_press(8'h35);
    check("full_a_done", inp_a, 32'h6b64b235);
    check("full_idx_after_a", {29'd0, byte_idx}, 32'd4);
    clean_press(8'h6a);
    clean_press(8'hc4);
    clean_press(8'h92);
    check("full_valid_before_last", {31'd0, operands_valid}, 32'd0);
    clean_press(8'h14);
    check("full_inp_a", inp_a, 32'h6b64b235);
    check("full_inp_b", inp_b, 32'h6ac49214);
    check("full_valid", {31'd0, operands_valid}, 32'd1);
    check("full_byte_idx", {29'd0, byte_idx}, 32'd0);
    check("full_ack_count", ack_cnt - ack_base, 32'd8);

    // Re-entry from DONE.
    ack_base = ack_cnt;
    clean_press(8'h3f);
    check("reentry_valid", {31'd0, operands_valid}, 32'd0);
    check("reentry_inp_a", inp_a, 32'h3f64b235);
    check("reentry_byte_idx", {29'd0, byte_idx}, 32'd1);
    check("reentry_inp_b", inp_b, 32'h6ac49214);
    check("reentry_ack_count", ack_cnt - ack_base, 32'd1);

    // Glitch rejection: 3-cycle pulses must not register.
    ack_base = ack_cnt;
    sw = 8'hee;
    repeat (3) begin
      noisy_level = 1'b1;
      tick(3);
      noisy_level = 1'b0;
      tick(10);
    end
    check("glitch_inp_a", inp_a, 32'h3f64b235);
    check("glitch_byte_idx", {29'd0, byte_idx}, 32'd1);
    check("glitch_ack_count", ack_cnt - ack_base, 32'd0);

    // Chattering press with release bounce: exactly one write.
    ack_base = ack_cnt;
    sw = 8'haa;
    noisy_level = 1'b1; tick(1);
    noisy_level = 1'b0; tick(1);
    noisy_level = 1'b1; tick(1);
    noisy_level = 1'b0; tick(1);
    noisy_level = 1'b1; tick(20);
    noisy_level = 1'b0; tick(1);
    noisy_level = 1'b1; tick(1);
    noisy_level = 1'b0; tick(1);
    noisy_level = 1'b1; tick(1);
    noisy_level = 1'b0; tick(20);
    check("chatter_inp_a", inp_a, 32'h3faab235);
    check("chatter_byte_idx", {29'd0, byte_idx}, 32'd2);
    check("chatter_ack_count", ack_cnt - ack_base, 32'd1);

    // Held button: one write for 500 cycles high.
    ack_base = ack_cnt;
    sw = 8'hcc;
    noisy_level = 1'b1;
    tick(500);
    noisy_level = 1'b0;
    tick(20);
    check("held_inp_a", inp_a, 32'h3faacc35);
    check("held_byte_idx", {29'd0, byte_idx}, 32'd3);
    check("held_ack_count", ack_cnt - ack_base, 32'd1);

    // Two more bytes -> five bytes into this entry, then reset.
    clean_press(8'h11);
    clean_press(8'h22);
    check("mid_inp_a", inp_a, 32'h3faacc11);
    check("mid_inp_b", inp_b, 32'h22c49214);
    check("mid_byte_idx", {29'd0, byte_idx}, 32'd5);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    tick(1);
    check("rst_mid_inp_a", inp_a, 32'h0);
    check("rst_mid_inp_b", inp_b, 32'h0);
    check("rst_mid_byte_idx", {29'd0, byte_idx}, 32'd0);
    check("rst_mid_valid", {31'd0, operands_valid}, 32'd0);
    clean_press(8'h5a);
    check("post_rst_inp_a", inp_a, 32'h5a000000);
    check("post_rst_inp_b", inp_b, 32'h0);
    check("post_rst_byte_idx", {29'd0, byte_idx}, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
